// File: rtl/collatz_inverse_decoder_if.sv
// Pin bundle of the TinyTapeout-style wrapper used by collatz_inverse_decoder.
// The master drives the input pins. The slave (the decoder) drives the output pins.
interface collatz_inverse_decoder_if;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ui_in,
    output uio_in,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );

  modport slave (
    input  ui_in,
    input  uio_in,
    output uo_out,
    output uio_out,
    output uio_oe
  );
endinterface

// File: rtl/collatz_inverse_decoder.sv
// collatz_inverse_decoder: rebuilds the Collatz start value N from a parity
// vector by running the trajectory backwards from 1, one step per cycle.
// Parity bytes are shifted in with wr, and a run is launched with start
// (ui_in[3:0] = L-1). An abort edge cancels a run. Status is reported on uio_out.
// Optional build macro COLLATZ_INV_SYNC_EN: when it is defined, uio_in[3:0] passes
// through a 2-flop synchronizer before edge detection, which adds 2 cycles to every
// control response.
module collatz_inverse_decoder #(
  parameter int NW = 16,
  parameter int VW = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena,
  collatz_inverse_decoder_if.slave   bus
);
  localparam int IW = $clog2(VW);
  localparam logic [NW-1:0] ONE   = NW'(1);
  localparam logic [NW-1:0] THREE = NW'(3);

  typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;

  state_t        state, state_next;
  logic [NW-1:0] n, n_next;
  logic [VW-1:0] vec, vec_next;
  logic [IW-1:0] idx, idx_next;
  logic          err_div, err_div_next;
  logic          err_ovf, err_ovf_next;

  logic [3:0]    ctl;
  logic [2:0]    trig, trig_prev;
  logic          wr_edge, start_edge, abort_edge, rd_sel;
  logic          bit_b;
  logic [NW-1:0] m, q, r;
  logic          unused_pins;

  // Exact quotient for the inverse odd step. The divisor is a constant, so this reduces to fixed logic.
  function automatic logic [NW-1:0] div3(input logic [NW-1:0] a);
    return a / THREE;
  endfunction

`ifdef COLLATZ_INV_SYNC_EN
  logic [3:0] sync_p0, sync_p1;

  // Two-flop synchronizer on the control pins. It freezes with ena like all other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else if (ena) begin
      sync_p0 <= bus.uio_in[3:0];
      sync_p1 <= sync_p0;
    end
  end

  assign ctl = sync_p1;
`else
  assign ctl = bus.uio_in[3:0];
`endif

  assign trig       = {ctl[3], ctl[1], ctl[0]};
  assign wr_edge    = trig[0] & ~trig_prev[0];
  assign start_edge = trig[1] & ~trig_prev[1];
  assign abort_edge = trig[2] & ~trig_prev[2];
  assign rd_sel     = ctl[2];

  // Previous-value register for wr/start/abort edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_prev <= '0;
    end else if (ena) begin
      trig_prev <= trig;
    end
  end

  // Inverse odd step: m = n-1 must be 3*q, with q odd and not 1.
  assign bit_b = vec[idx];
  assign m     = n - ONE;
  assign q     = div3(m);
  assign r     = m - (q + (q << 1));

  // Next-state and datapath update for the decoder FSM.
  always_comb begin
    state_next   = state;
    n_next       = n;
    vec_next     = vec;
    idx_next     = idx;
    err_div_next = err_div;
    err_ovf_next = err_ovf;
    case (state)
      RUN: begin
        if (abort_edge) begin
          state_next   = IDLE;
          n_next       = ONE;
          err_div_next = 1'b0;
          err_ovf_next = 1'b0;
        end else begin
          if (bit_b) begin
            if ((r != '0) || !q[0] || (q == ONE)) begin
              err_div_next = 1'b1;
              state_next   = ERR;
            end else begin
              n_next = q;
            end
          end else begin
            if (n[NW-1]) begin
              err_ovf_next = 1'b1;
              state_next   = ERR;
            end else begin
              n_next = {n[NW-2:0], 1'b0};
            end
          end
          if (state_next == RUN) begin
            if (idx == '0) begin
              state_next = DONE;
            end else begin
              idx_next = idx - 1'b1;
            end
          end
        end
      end
      default: begin
        // A write in the same cycle lands in vec before the run reads it.
        if (wr_edge) begin
          vec_next = {vec[VW-9:0], bus.ui_in};
        end
        if (start_edge) begin
          n_next       = ONE;
          idx_next     = bus.ui_in[IW-1:0];
          err_div_next = 1'b0;
          err_ovf_next = 1'b0;
          state_next   = RUN;
        end
      end
    endcase
  end

  // State and datapath registers. They hold while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      n       <= ONE;
      vec     <= '0;
      idx     <= '0;
      err_div <= 1'b0;
      err_ovf <= 1'b0;
    end else if (ena) begin
      state   <= state_next;
      n       <= n_next;
      vec     <= vec_next;
      idx     <= idx_next;
      err_div <= err_div_next;
      err_ovf <= err_ovf_next;
    end
  end

  assign bus.uo_out  = rd_sel ? n[15:8] : n[7:0];
  assign bus.uio_out = {err_ovf, err_div, (state == DONE) || (state == ERR), state == RUN, 4'b0000};
  assign bus.uio_oe  = 8'hF0;

  assign unused_pins = ^bus.uio_in[7:4];
endmodule

// File: tb/tb_collatz_inverse_decoder.sv
// Bench for collatz_inverse_decoder. Expected results for each run are pushed
// into a scoreboard, and a monitor checks them when done rises.
module tb_collatz_inverse_decoder;
`ifdef COLLATZ_INV_SYNC_EN
  localparam int S = 2;
`else
  localparam int S = 0;
`endif

  typedef struct {
    logic [15:0] n;
    logic        div;
    logic        ovf;
    int          lat;
    int          busy;
    int          c0;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  collatz_inverse_decoder_if bus();

  collatz_inverse_decoder #(.NW(16), .VW(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: count busy cycles and score each rising edge of done.
  logic done_prev = 1'b0;
  logic busy_prev = 1'b0;
  int   busy_cnt = 0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (bus.uio_out[4] === 1'b1 && busy_prev !== 1'b1) busy_cnt = 0;
    if (bus.uio_out[4] === 1'b1) busy_cnt++;
    if (bus.uio_out[5] === 1'b1 && done_prev !== 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 with n_lo=0x%0h, expected no completion", bus.uo_out);
      end else begin
        mon_e = sb_q.pop_front();
        check("result_lo", {24'h0, bus.uo_out}, {24'h0, mon_e.n[7:0]});
        check("status", {24'h0, bus.uio_out}, {24'h0, mon_e.ovf, mon_e.div, 1'b1, 1'b0, 4'b0000});
        check("latency", cyc - mon_e.c0, mon_e.lat);
        check("busy_cycles", busy_cnt, mon_e.busy);
      end
    end
    done_prev = bus.uio_out[5];
    busy_prev = bus.uio_out[4];
  end

  task automatic ctl_pulse(input int bitn, input logic [7:0] b);
    @(negedge clk);
    bus.ui_in = b;
    bus.uio_in[bitn] = 1'b1;
    @(negedge clk);
    bus.uio_in[bitn] = 1'b0;
    repeat (S + 1) @(negedge clk);
  endtask

  // Launch a run and queue its expected outcome; steps counts executed steps.
  task automatic start_exp(input logic [3:0] lm1, input logic [15:0] n, input logic div,
                           input logic ovf, input int steps, input int extra);
    exp_t e;
    @(negedge clk);
    bus.ui_in = {4'h0, lm1};
    bus.uio_in[1] = 1'b1;
    e.n = n;
    e.div = div;
    e.ovf = ovf;
    e.lat = steps + 1 + S + extra;
    e.busy = steps + extra;
    e.c0 = cyc;
    sb_q.push_back(e);
    @(negedge clk);
    bus.uio_in[1] = 1'b0;
  endtask

  task automatic start_only(input logic [3:0] lm1);
    @(negedge clk);
    bus.ui_in = {4'h0, lm1};
    bus.uio_in[1] = 1'b1;
    @(negedge clk);
    bus.uio_in[1] = 1'b0;
  endtask

  task automatic wait_sb();
    int k = 0;
    while (sb_q.size() != 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got %0d runs pending, expected 0", sb_q.size());
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_busy();
    int k = 0;
    while (bus.uio_out[4] !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (bus.uio_out[4] !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL busy_timeout: got busy=%b, expected 1", bus.uio_out[4]);
    end
  endtask

  task automatic read_hi(input string name, input logic [7:0] exp);
    @(negedge clk);
    bus.uio_in[2] = 1'b1;
    repeat (S + 1) @(negedge clk);
    check(name, {24'h0, bus.uo_out}, {24'h0, exp});
    bus.uio_in[2] = 1'b0;
    repeat (S + 1) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.ui_in = 8'h00;
    bus.uio_in = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_uo_out", {24'h0, bus.uo_out}, 32'h01);
    check("reset_uio_out", {24'h0, bus.uio_out}, 32'h00);
    check("reset_uio_oe", {24'h0, bus.uio_oe}, 32'hF0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // N=6: vector 0x0A, L=8.
    ctl_pulse(0, 8'h0A);
    start_exp(4'd7, 16'h0006, 1'b0, 1'b0, 8, 0);
    wait_sb();
    read_hi("n6_hi", 8'h00);

    // All-zero vector: 15 doublings reach 0x8000; a 16th overflows.
    ctl_pulse(0, 8'h00);
    ctl_pulse(0, 8'h00);
    start_exp(4'd14, 16'h8000, 1'b0, 1'b0, 15, 0);
    wait_sb();
    read_hi("l15_hi", 8'h80);
    start_exp(4'd15, 16'h8000, 1'b0, 1'b1, 16, 0);
    wait_sb();
    read_hi("ovf_hi", 8'h80);

    // Divisibility errors: q=0 at n=1, then q==1 at n=4.
    ctl_pulse(0, 8'h01);
    start_exp(4'd0, 16'h0001, 1'b1, 1'b0, 1, 0);
    wait_sb();
    ctl_pulse(0, 8'h01);
    start_exp(4'd2, 16'h0004, 1'b1, 1'b0, 3, 0);
    wait_sb();

    // Abort during a run, then a clean re-run.
    ctl_pulse(0, 8'h00);
    ctl_pulse(0, 8'h0A);
    start_only(4'd7);
    wait_busy();
    repeat (3) @(negedge clk);
    bus.uio_in[3] = 1'b1;
    @(negedge clk);
    bus.uio_in[3] = 1'b0;
    repeat (S + 2) @(negedge clk);
    check("abort_status", {24'h0, bus.uio_out}, 32'h00);
    check("abort_n", {24'h0, bus.uo_out}, 32'h01);
    start_exp(4'd7, 16'h0006, 1'b0, 1'b0, 8, 0);
    wait_sb();

    // ena low for 5 cycles mid-run delays done by exactly 5.
    start_exp(4'd7, 16'h0006, 1'b0, 1'b0, 8, 5);
    wait_busy();
    repeat (2) @(negedge clk);
    ena = 1'b0;
    repeat (5) @(negedge clk);
    ena = 1'b1;
    wait_sb();

    // Asynchronous reset mid-run.
    start_only(4'd7);
    wait_busy();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_uo_out", {24'h0, bus.uo_out}, 32'h01);
    check("arst_uio_out", {24'h0, bus.uio_out}, 32'h00);
    check("arst_uio_oe", {24'h0, bus.uio_oe}, 32'hF0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Simultaneous wr and start: vec becomes 0x0007, L=8, err_div at n=32.
    @(negedge clk);
    bus.ui_in = 8'h07;
    bus.uio_in[1:0] = 2'b11;
    begin
      exp_t e;
      e.n = 16'h0020;
      e.div = 1'b1;
      e.ovf = 1'b0;
      e.lat = 6 + 1 + S;
      e.busy = 6;
      e.c0 = cyc;
      sb_q.push_back(e);
    end
    @(negedge clk);
    bus.uio_in[1:0] = 2'b00;
    wait_sb();

    // Stale upper vector bits (0x07 in vec[15:8]) are ignored.
    ctl_pulse(0, 8'h0A);
    start_exp(4'd7, 16'h0006, 1'b0, 1'b0, 8, 0);
    wait_sb();

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/collatz_inverse_decoder.md
Name: collatz_inverse_decoder

Overview:
- Inverse of the Collatz iteration engine in this design.
- The forward engine turns a start value N into a trajectory whose per-step parities form a parity vector (0 = even step n/2, 1 = odd step 3n+1).
- This block takes that parity vector and its length, runs the steps backwards from the terminal value 1, and reconstructs N.
- It sits in the same TinyTapeout-style wrapper and uses the same pin grouping.

Parameters:
- NW, 16, width of the reconstructed-value accumulator in bits.
- VW, 16, maximum parity-vector length in bits (two bytes).

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  design enable; when 0, all registers hold.
- ui_in  input  8  parity byte on write; ui_in[3:0] = L-1 on start.
- uio_in  input  8  [0] wr, [1] start, [2] rd_sel, [3] abort; [7:4] unused.
- uo_out  output  8  result byte: rd_sel=0 gives n[7:0], rd_sel=1 gives n[15:8].
- uio_out  output  8  [3:0]=0; [4] busy, [5] done, [6] err_div, [7] err_ovf.
- uio_oe  output  8  constant 8'hF0.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, n=1, vec=0, idx=0; busy, done, err_div, err_ovf = 0. uio_oe is constant.
- Edge detection: wr, start and abort act on rising edges (registered previous value); rd_sel is level.
- wr edge: vec <= {vec[7:0], ui_in}.
  - For L>8, write bits p15..p8 first, then p7..p0.
  - Bit i of vec = p[i], the parity of the i-th forward step.
  - wr is ignored while busy.
- start edge, accepted in IDLE/DONE/ERR only:
  - L-1 <= ui_in[3:0];
  - n <= 1;
  - idx <= L-1;
  - clear done and both error flags;
  - go to RUN. busy rises the next cycle.
- RUN, one step per cycle using b = vec[idx]:
  - b=0: if n[NW-1]=1, set err_ovf and go to ERR; else n <= n<<1.
  - b=1: let m = n-1. If m mod 3 != 0, or q = m/3 is even, or q == 1, set err_div and go to ERR. Otherwise n <= q. Use a constant-divide by 3, computed combinationally.
  - If idx==0 after the step, go to DONE; else idx <= idx-1.
- Latency: exactly L cycles in RUN. done=1 on the cycle after the last step. Total = L+1 cycles from the start edge to done.
- DONE: busy=0, done=1, n stable.
- ERR: busy=0, done=1, one error flag=1, n holds its value from before the failing step.
- abort edge during RUN: go to IDLE with busy=0, done=0, flags cleared, n=1. Ignored in other states.
- Simultaneous start and abort edges in RUN: abort wins. Simultaneous wr and start in IDLE: the write happens first, and start uses the updated vec.
- ena=0 mid-run: freeze all state including the edge-detect registers. Resume on ena=1 with no lost or extra step.
- Asynchronous reset mid-run: immediate return to reset values. No partial result is kept.
- L is 1..16 via L-1. A start with stale vec bits above L-1 is legal; those bits are ignored.

Optional Feature:
- Macro COLLATZ_INV_SYNC_EN.
- Defined: uio_in[3:0] pass through a 2-flop synchronizer before edge detection. Every control response (wr capture, start accept, abort) shifts 2 cycles later, so start-to-done = L+3. rd_sel also gets 2 cycles of delay.
- Undefined: controls are sampled directly, with the latencies above.

Test Plan:
- N=6 decode:
  - Stimulus: wr ui_in=0x0A; start with ui_in=0x07.
  - Response: busy for 8 cycles; done with no errors; rd_sel=0 gives uo_out=0x06; rd_sel=1 gives 0x00.
- Two-byte vector:
  - Stimulus: wr 0x00, wr 0x00; start with L-1=14.
  - Response: n=0x8000 after 15 steps, no error.
  - Then start with L-1=15: err_ovf=1 on step 16, done=1, n=0x8000.
- Divisibility error:
  - Stimulus: wr 0x01; start with L-1=0. (n=1 gives q=0, even.)
  - Response: err_div=1, done=1, n=0x0001.
  - Stimulus: wr 0x01; start with L-1=2.
  - Response: q==1 at the last step gives err_div=1, n=0x0004.
- Abort and re-start:
  - Stimulus: start N=6 vector; abort edge on the 4th RUN cycle.
  - Response: busy=0, done=0, flags 0. A new start reproduces 0x06 with no residue.
- ena and reset:
  - Stimulus: drop ena for 5 cycles mid-run.
  - Response: result 0x06 with done delayed exactly 5 cycles.
  - Stimulus: pulse rst_n low mid-run.
  - Response: outputs immediately show n=1, all status 0, uio_oe=0xF0.
- With COLLATZ_INV_SYNC_EN:
  - Stimulus: repeat the N=6 case.
  - Response: done asserts 2 cycles later than in the unsynchronized build; same result.
